// File: rtl/fft_pipe_ctrl.sv
// Sequencer for the streaming FFT stage chain: loader handshake, per-stage write-enable delay line,
// flush/done/abort control. Optional loader stall counter is built when FFT_CTRL_STALL_CNT_EN is defined.
module fft_pipe_ctrl #(
    parameter int NUMSTAGES    = 5,
    parameter int NUMSAMPLES   = 32,
    parameter int LANES        = 4,
    parameter int TOTALSAMPLES = 96,
    parameter int STAGE_LAT    = 1,
    localparam int BPF = NUMSAMPLES / LANES,
    localparam int NFR = TOTALSAMPLES / NUMSAMPLES,
    localparam int BW  = (BPF > 1) ? $clog2(BPF) : 1,
    localparam int FW  = (NFR > 1) ? $clog2(NFR) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 in_valid,
    output logic                 ld_req,
    output logic                 en,
    output logic [NUMSTAGES-1:0] wr_en,
    output logic                 out_valid,
    output logic [BW-1:0]        beat_idx,
    output logic [FW-1:0]        frame_idx,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          stall_cnt,
    output logic [1:0]           dbg_state
);

    localparam int DEPTH = NUMSTAGES * STAGE_LAT;
    localparam int CW    = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, LOADING, FLUSH, DONE} state_t;

    state_t         state_q, state_d;
    logic [BW-1:0]  beat_q;
    logic [FW-1:0]  frame_q;
    logic [CW-1:0]  flush_q;
    logic [DEPTH:0] chain_q;
    logic           accept;
    logic           kill;
    logic           last_beat;

    // Handshake: a beat transfers on a cycle with ld_req=1 and in_valid=1, unless abort is high.
    assign accept    = (state_q == LOADING) && in_valid && !abort;
    assign kill      = abort && ((state_q == LOADING) || (state_q == FLUSH));
    assign last_beat = (beat_q == BW'(BPF - 1)) && (frame_q == FW'(NFR - 1));

    always_comb begin
        state_d   = state_q;
        ld_req    = 1'b0;
        en        = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        wr_en     = '0;
        out_valid = chain_q[DEPTH];
        for (int k = 0; k < NUMSTAGES; k++) begin
            wr_en[k] = chain_q[k*STAGE_LAT];
        end
        case (state_q)
            IDLE: begin
                if (start && !abort) state_d = LOADING;
            end
            LOADING: begin
                ld_req = 1'b1;
                en     = 1'b1;
                busy   = 1'b1;
                if (abort) state_d = IDLE;
                else if (accept && last_beat) state_d = FLUSH;
            end
            FLUSH: begin
                en   = 1'b1;
                busy = 1'b1;
                if (abort) state_d = IDLE;
                else if (flush_q == CW'(DEPTH - 1)) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            frame_q <= '0;
            flush_q <= '0;
            chain_q <= '0;
        end else begin
            state_q <= state_d;
            // Tap k*STAGE_LAT of this line is wr_en[k]; the last tap is out_valid.
            if (kill) chain_q <= '0;
            else      chain_q <= {chain_q[DEPTH-1:0], accept};

            if (kill || state_q == DONE) begin
                beat_q  <= '0;
                frame_q <= '0;
            end else if (accept) begin
                if (beat_q == BW'(BPF - 1)) begin
                    beat_q <= '0;
                    // The final frame index is held until the run ends.
                    if (frame_q != FW'(NFR - 1)) frame_q <= frame_q + 1'b1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end

            if (state_q == FLUSH) flush_q <= flush_q + 1'b1;
            else                  flush_q <= '0;
        end
    end

`ifdef FFT_CTRL_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && state_d == LOADING) begin
            stall_q <= '0;
        end else if (state_q == LOADING && !in_valid && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

    assign beat_idx  = beat_q;
    assign frame_idx = frame_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fft_pipe_ctrl.sv
// Scoreboard bench for fft_pipe_ctrl: a cycle-level phase model in the driver predicts control outputs,
// accepted-beat indices and out_valid arrival times; a negedge monitor compares against the DUT.
module tb_fft_pipe_ctrl;

  localparam int NS    = 5;
  localparam int NSMP  = 32;
  localparam int LN    = 4;
  localparam int TOT   = 96;
  localparam int SL    = 1;
  localparam int BPF   = NSMP / LN;
  localparam int NFR   = TOT / NSMP;
  localparam int BW    = (BPF > 1) ? $clog2(BPF) : 1;
  localparam int FW    = (NFR > 1) ? $clog2(NFR) : 1;
  localparam int DEPTH = NS * SL;
  localparam int MAXC  = 8000;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_FLUSH = 2;
  localparam int M_DONE  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic in_valid = 1'b0;
  logic ld_req, en, out_valid, busy, done;
  logic [NS-1:0] wr_en;
  logic [BW-1:0] beat_idx;
  logic [FW-1:0] frame_idx;
  logic [15:0] stall_cnt;
  logic [1:0] dbg_state;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  fft_pipe_ctrl #(
    .NUMSTAGES(NS), .NUMSAMPLES(NSMP), .LANES(LN), .TOTALSAMPLES(TOT), .STAGE_LAT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .in_valid(in_valid),
    .ld_req(ld_req), .en(en), .wr_en(wr_en), .out_valid(out_valid),
    .beat_idx(beat_idx), .frame_idx(frame_idx), .busy(busy), .done(done),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [BW+FW-1:0] exp_q[$];   // indices of each accepted beat
  logic [31:0]      ov_q[$];    // cycle in which each out_valid pulse is due
  logic [3:0]       exp_ctl [MAXC];
  logic [15:0]      exp_stall [MAXC];
  bit               exp_set [MAXC];
  bit               acc_hist [MAXC];
  int last_abort = -1;
  int n_cmp = 0;
  int n_err = 0;

  int m_phase = M_IDLE;
  int m_n = 0;
  int m_flush = 0;
  int m_stall = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic kill_run(input int t);
    logic [31:0] keep[$];
    last_abort = t;
    foreach (ov_q[i]) if (ov_q[i] <= t) keep.push_back(ov_q[i]);
    ov_q = keep;
    m_n = 0;
    m_phase = M_IDLE;
  endtask

  // ---------------- driver + reference model ----------------
  task automatic step(input logic s, input logic a, input logic v, input logic r);
    int t;
    @(posedge clk);
    #1;
    t = cyc;
    start = s; abort = a; in_valid = v; rst_n = r;
    if (t >= MAXC) begin
      n_err++;
      $display("FAIL cycle_budget cycle %0d: got over limit expected below %0d", t, MAXC);
      $fatal(1, "cycle budget exceeded");
    end
    exp_ctl[t] = {m_phase != M_IDLE, m_phase == M_LOAD,
                  m_phase == M_LOAD || m_phase == M_FLUSH, m_phase == M_DONE};
`ifdef FFT_CTRL_STALL_CNT_EN
    exp_stall[t] = 16'(m_stall);
`else
    exp_stall[t] = 16'h0000;
`endif
    exp_set[t] = 1'b1;
    if (!r) begin
      kill_run(t);
      m_stall = 0;
    end else begin
      case (m_phase)
        M_IDLE: if (s && !a) begin m_phase = M_LOAD; m_n = 0; m_stall = 0; end
        M_LOAD: begin
          if (!v && m_stall != 16'hFFFF) m_stall++;
          if (a) kill_run(t);
          else if (v) begin
            exp_q.push_back({FW'(m_n / BPF), BW'(m_n % BPF)});
            acc_hist[t] = 1'b1;
            ov_q.push_back(32'(t + 1 + DEPTH));
            m_n++;
            if (m_n == NFR * BPF) begin m_phase = M_FLUSH; m_flush = DEPTH; end
          end
        end
        M_FLUSH: begin
          if (a) kill_run(t);
          else begin
            m_flush--;
            if (m_flush == 0) m_phase = M_DONE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  endtask

  // mode: 0 in_valid always 1, 1 single gap at relative cycle 5, 2 random gaps
  // kill_kind: 0 none, 1 abort at relative cycle kill_at, 2 abort at flush step kill_at, 3 reset there
  task automatic run(input int mode, input int kill_kind, input int kill_at);
    int rel;
    logic v, a, r, s;
    step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    rel = 1;
    while (m_phase != M_IDLE && rel < 400) begin
      v = 1'b1;
      if (mode == 1) v = (rel != 5);
      if (mode == 2) v = ($urandom_range(0, 3) != 0);
      a = 1'b0;
      r = 1'b1;
      if (kill_kind == 1 && rel == kill_at) a = 1'b1;
      if (kill_kind == 2 && m_phase == M_FLUSH && m_flush == kill_at) a = 1'b1;
      if (kill_kind == 3 && m_phase == M_FLUSH && m_flush == kill_at) r = 1'b0;
      s = ($urandom_range(0, 7) == 0);
      step(s, a, v, r);
      rel++;
    end
    if (rel >= 400) begin
      n_err++;
      $display("FAIL run_timeout cycle %0d: got still busy expected idle", cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [NS:0] ew;
    logic [BW+FW-1:0] e;
    logic [31:0] due;
    int s;
    forever begin
      @(negedge clk);
      if (cyc < MAXC && exp_set[cyc]) begin
        chk("ctl_busy_ldreq_en_done", {60'd0, busy, ld_req, en, done}, {60'd0, exp_ctl[cyc]});
        chk("stall_cnt", {48'd0, stall_cnt}, {48'd0, exp_stall[cyc]});
        for (int k = 0; k <= NS; k++) begin
          s = cyc - 1 - k * SL;
          ew[k] = (s >= 0) && acc_hist[s] && (s > last_abort || cyc <= last_abort);
        end
        chk("wr_en", {{(64-NS){1'b0}}, wr_en}, {{(64-NS){1'b0}}, ew[NS-1:0]});
        if (!exp_ctl[cyc][3])
          chk("idx_idle", {{(64-BW-FW){1'b0}}, frame_idx, beat_idx}, 64'd0);
        if (ld_req && in_valid && !abort && rst_n) begin
          if (exp_q.size() == 0) chk("accept_extra", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("beat_frame_idx", {{(64-BW-FW){1'b0}}, frame_idx, beat_idx}, {{(64-BW-FW){1'b0}}, e});
          end
        end
        if (out_valid) begin
          if (ov_q.size() == 0) chk("out_valid_extra", 64'd1, 64'd0);
          else begin
            due = ov_q.pop_front();
            chk("out_valid_cycle", 64'(cyc), {32'd0, due});
          end
        end
      end
    end
  end

  // ---------------- stimulus sequence ----------------
  initial begin
    repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    run(0, 0, 0);              idle(4);
    run(1, 0, 0);              idle(3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(3);
    run(0, 1, 10);             idle(2);
    run(0, 0, 0);              idle(2);
    run(0, 3, 3);              idle(3);
    run(2, 2, 1);              idle(2);
    repeat (6) begin
      run(2, 0, 0);
      idle($urandom_range(1, 6));
    end
    run(2, 1, $urandom_range(2, 20));
    idle(DEPTH + 10);
    @(negedge clk);
    #1;
    chk("accept_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("out_valid_queue_empty", 64'(ov_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
